// File: rtl/msrv32_pkg.sv
// Shared types and constants for the writeback scheduler slice.
package msrv32_pkg;

  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_CNT_W     = 4;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_FORCE_B = 1'b1
  } wb_state_e;

endpackage

// File: rtl/msrv32_scoreboard.sv
// Pending-write scoreboard for long-latency destinations plus decode hazard detection.
module msrv32_scoreboard (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       set_en_in,
  input  logic [4:0] set_addr_in,
  input  logic       clr_en_in,
  input  logic [4:0] clr_addr_in,
  input  logic [4:0] rs_1_addr_in,
  input  logic [4:0] rs_2_addr_in,
  output logic       hazard_out,
  output logic       clr_unpending_out
);

  logic [31:0] r_pending;
  logic [31:0] w_set_mask;
  logic [31:0] w_clr_mask;
  logic        w_rs_1_busy;
  logic        w_rs_2_busy;

  // x0 is never tracked; set wins over clear because it is OR-ed in last.
  always_comb begin
    w_set_mask = 32'd0;
    w_clr_mask = 32'd0;
    if (set_en_in && (set_addr_in != 5'd0)) begin
      w_set_mask = 32'd1 << set_addr_in;
    end else begin
      w_set_mask = 32'd0;
    end
    if (clr_en_in) begin
      w_clr_mask = 32'd1 << clr_addr_in;
    end else begin
      w_clr_mask = 32'd0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pending <= 32'd0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end
  end

  // A source being written back this cycle is forwarded, so it does not stall.
  always_comb begin
    w_rs_1_busy = (rs_1_addr_in != 5'd0) && r_pending[rs_1_addr_in] &&
                  !(clr_en_in && (clr_addr_in == rs_1_addr_in));
    w_rs_2_busy = (rs_2_addr_in != 5'd0) && r_pending[rs_2_addr_in] &&
                  !(clr_en_in && (clr_addr_in == rs_2_addr_in));
    hazard_out  = !rst_in && (w_rs_1_busy || w_rs_2_busy);
    clr_unpending_out = clr_en_in && (clr_addr_in != 5'd0) && !r_pending[clr_addr_in];
  end

endmodule

// File: rtl/msrv32_wb_scheduler.sv
// Writeback port arbiter between stage-3 (A) and long-latency loads (B) with B starvation guard.
module msrv32_wb_scheduler
  import msrv32_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        a_valid_in,
  input  logic [4:0]  a_rd_addr_in,
  input  logic [31:0] a_rd_data_in,
  output logic        a_ready_out,
  input  logic        b_valid_in,
  input  logic [4:0]  b_rd_addr_in,
  input  logic [31:0] b_rd_data_in,
  output logic        b_ready_out,
  input  logic        issue_valid_in,
  input  logic [4:0]  issue_rd_addr_in,
  input  logic [4:0]  rs_1_addr_in,
  input  logic [4:0]  rs_2_addr_in,
  output logic        hazard_out,
  output logic [4:0]  rd_addr_out,
  output logic        wr_en_out,
  output logic [31:0] rd_out,
  output logic        proto_err_out
);

  localparam logic [STARVE_CNT_W-1:0] LP_CNT_LAST = STARVE_CNT_W'(STARVE_LIMIT - 1);

  wb_state_e               r_state;
  wb_state_e               w_state_nxt;
  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic [STARVE_CNT_W-1:0] w_starve_cnt_nxt;
  logic                    w_grant_a;
  logic                    w_grant_b;
  logic                    w_b_dropped;
  logic                    w_clr_unpending;
  logic                    r_proto_err;

  always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state      <= ST_NORMAL;
      r_starve_cnt <= {STARVE_CNT_W{1'b0}};
      r_proto_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
      r_proto_err  <= r_proto_err | w_b_dropped | w_clr_unpending;
    end
  end

  // Grants are gated by reset so nothing reaches the register file while it is held.
  always_comb begin
    w_grant_a        = 1'b0;
    w_grant_b        = 1'b0;
    w_b_dropped      = 1'b0;
    w_state_nxt      = ST_NORMAL;
    w_starve_cnt_nxt = {STARVE_CNT_W{1'b0}};
    if (!ms_riscv32_mp_rst_in) begin
      case (r_state)
        ST_NORMAL: begin
          if (a_valid_in) begin
            w_grant_a = 1'b1;
          end else begin
            w_grant_b = b_valid_in;
          end
          if (b_valid_in && !w_grant_b) begin
            if (r_starve_cnt == LP_CNT_LAST) begin
              w_state_nxt      = ST_FORCE_B;
              w_starve_cnt_nxt = {STARVE_CNT_W{1'b0}};
            end else begin
              w_state_nxt      = ST_NORMAL;
              w_starve_cnt_nxt = r_starve_cnt + {{(STARVE_CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            w_state_nxt      = ST_NORMAL;
            w_starve_cnt_nxt = {STARVE_CNT_W{1'b0}};
          end
        end
        ST_FORCE_B: begin
          w_grant_b   = b_valid_in;
          w_b_dropped = !b_valid_in;
          w_state_nxt = ST_NORMAL;
        end
        default: begin
          w_state_nxt = ST_NORMAL;
        end
      endcase
    end else begin
      w_grant_a   = 1'b0;
      w_grant_b   = 1'b0;
      w_state_nxt = ST_NORMAL;
    end
  end

  always_comb begin
    a_ready_out = w_grant_a;
    b_ready_out = w_grant_b;
    rd_addr_out = 5'd0;
    rd_out      = 32'd0;
    if (w_grant_a) begin
      rd_addr_out = a_rd_addr_in;
      rd_out      = a_rd_data_in;
    end else if (w_grant_b) begin
      rd_addr_out = b_rd_addr_in;
      rd_out      = b_rd_data_in;
    end else begin
      rd_addr_out = 5'd0;
      rd_out      = 32'd0;
    end
    wr_en_out     = (w_grant_a || w_grant_b) && (rd_addr_out != 5'd0);
    proto_err_out = r_proto_err && !ms_riscv32_mp_rst_in;
  end

  msrv32_scoreboard u_scoreboard (
    .clk_in            (ms_riscv32_mp_clk_in),
    .rst_in            (ms_riscv32_mp_rst_in),
    .set_en_in         (issue_valid_in),
    .set_addr_in       (issue_rd_addr_in),
    .clr_en_in         (w_grant_b),
    .clr_addr_in       (b_rd_addr_in),
    .rs_1_addr_in      (rs_1_addr_in),
    .rs_2_addr_in      (rs_2_addr_in),
    .hazard_out        (hazard_out),
    .clr_unpending_out (w_clr_unpending)
  );

endmodule

// File: tb/tb_msrv32_wb_scheduler.sv
// Directed self-checking bench for msrv32_wb_scheduler.
module tb_msrv32_wb_scheduler;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic        b_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        hazard;
  logic [4:0]  rd_addr;
  logic        wr_en;
  logic [31:0] rd_data;
  logic        proto_err;

  int errors = 0;
  int checks = 0;

  msrv32_wb_scheduler #(.STARVE_LIMIT(4)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .a_valid_in           (a_valid),
    .a_rd_addr_in         (a_addr),
    .a_rd_data_in         (a_data),
    .a_ready_out          (a_ready),
    .b_valid_in           (b_valid),
    .b_rd_addr_in         (b_addr),
    .b_rd_data_in         (b_data),
    .b_ready_out          (b_ready),
    .issue_valid_in       (issue_valid),
    .issue_rd_addr_in     (issue_rd),
    .rs_1_addr_in         (rs1),
    .rs_2_addr_in         (rs2),
    .hazard_out           (hazard),
    .rd_addr_out          (rd_addr),
    .wr_en_out            (wr_en),
    .rd_out               (rd_data),
    .proto_err_out        (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
    issue_valid = 1'b0; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h0000_0001;
    b_valid = 1'b1; b_addr = 5'd4;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready got=%0b exp=0", a_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready got=%0b exp=0", b_ready); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got=%0b exp=0", wr_en); end
    checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL rst_rd_addr got=%0d exp=0", rd_addr); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rst_rd_out got=%h exp=0", rd_data); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL rst_hazard got=%0b exp=0", hazard); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto got=%0b exp=0", proto_err); end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_a_only;
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL a_only_wr_en got=%0b exp=1", wr_en); end
    checks++; if (rd_addr !== 5'd5) begin errors++; $display("FAIL a_only_rd_addr got=%0d exp=5", rd_addr); end
    checks++; if (rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL a_only_rd_out got=%h exp=deadbeef", rd_data); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL a_only_a_ready got=%0b exp=1", a_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL a_only_b_ready got=%0b exp=0", b_ready); end
    a_addr = 5'd0;
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL a_x0_wr_en got=%0b exp=0", wr_en); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL a_x0_a_ready got=%0b exp=1", a_ready); end
    idle_inputs();
    tick();
  endtask

  task automatic test_hazard;
    issue_valid = 1'b1; issue_rd = 5'd7; rs1 = 5'd7;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL haz_cycle0 got=%0b exp=0", hazard); end
    tick();
    issue_valid = 1'b0;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_cycle1 got=%0b exp=1", hazard); end
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'h0000_00A7;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_a_write got=%0b exp=1", hazard); end
    tick();
    a_valid = 1'b0;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_after_a got=%0b exp=1", hazard); end
    rs1 = 5'd0; rs2 = 5'd7;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL haz_rs2 got=%0b exp=1", hazard); end
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0000_1234;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL haz_b_ready got=%0b exp=1", b_ready); end
    checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL haz_b_wr_en got=%0b exp=1", wr_en); end
    checks++; if (rd_addr !== 5'd7) begin errors++; $display("FAIL haz_b_rd_addr got=%0d exp=7", rd_addr); end
    checks++; if (rd_data !== 32'h0000_1234) begin errors++; $display("FAIL haz_b_rd_out got=%h exp=00001234", rd_data); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL haz_fwd got=%0b exp=0", hazard); end
    tick();
    b_valid = 1'b0;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL haz_cleared got=%0b exp=0", hazard); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL haz_proto got=%0b exp=0", proto_err); end
    idle_inputs();
    tick();
  endtask

  task automatic test_starve;
    issue_valid = 1'b1; issue_rd = 5'd2;
    tick();
    issue_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h1111_1111;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL starve_pre%0d_b_ready got=%0b exp=0", i, b_ready); end
      tick();
    end
    b_valid = 1'b0;
    tick();
    b_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
        errors++; $display("FAIL starve_deny%0d got a=%0b b=%0b exp a=1 b=0", i, a_ready, b_ready);
      end
      tick();
    end
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL force_a_ready got=%0b exp=0", a_ready); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL force_b_ready got=%0b exp=1", b_ready); end
    checks++; if (rd_addr !== 5'd2) begin errors++; $display("FAIL force_rd_addr got=%0d exp=2", rd_addr); end
    checks++; if (rd_data !== 32'h2222_2222) begin errors++; $display("FAIL force_rd_out got=%h exp=22222222", rd_data); end
    tick();
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL after_force got a=%0b b=%0b exp a=1 b=0", a_ready, b_ready);
    end
    checks++; if (rd_addr !== 5'd1) begin errors++; $display("FAIL after_force_rd_addr got=%0d exp=1", rd_addr); end
    idle_inputs();
    tick();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL starve_proto got=%0b exp=0", proto_err); end
  endtask

  task automatic test_same_cycle;
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h0000_0033;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL same_b_ready got=%0b exp=1", b_ready); end
    tick();
    issue_valid = 1'b0; b_valid = 1'b0; rs1 = 5'd3;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL same_still_pending got=%0b exp=1", hazard); end
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL same_drained got=%0b exp=0", hazard); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL same_proto got=%0b exp=0", proto_err); end
    idle_inputs();
    tick();
  endtask

  task automatic test_proto;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h0000_0099;
    #1;
    checks++; if (wr_en !== 1'b1 || b_ready !== 1'b1) begin
      errors++; $display("FAIL proto_b9 got wr=%0b b=%0b exp wr=1 b=1", wr_en, b_ready);
    end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_early got=%0b exp=0", proto_err); end
    tick();
    b_valid = 1'b0;
    #1;
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_set got=%0b exp=1", proto_err); end
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h0000_00FF;
    #1;
    checks++; if (wr_en !== 1'b0 || b_ready !== 1'b1 || rd_addr !== 5'd0) begin
      errors++; $display("FAIL proto_b_x0 got wr=%0b b=%0b addr=%0d exp wr=0 b=1 addr=0", wr_en, b_ready, rd_addr);
    end
    tick();
    b_valid = 1'b0;
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'h0000_FFFF;
    #1;
    checks++; if (wr_en !== 1'b0 || a_ready !== 1'b1) begin
      errors++; $display("FAIL proto_a_x0 got wr=%0b a=%0b exp wr=0 a=1", wr_en, a_ready);
    end
    idle_inputs();
    repeat (3) tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky got=%0b exp=1", proto_err); end
  endtask

  task automatic test_reset_in_force;
    issue_valid = 1'b1; issue_rd = 5'd20;
    tick();
    issue_valid = 1'b0; rs1 = 5'd20;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL rif_hazard_pre got=%0b exp=1", hazard); end
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h0000_0001;
    b_valid = 1'b1; b_addr = 5'd20; b_data = 32'h0000_0020;
    repeat (4) tick();
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL rif_in_force got=%0b exp=1", b_ready); end
    rst = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++; $display("FAIL rif_ready got a=%0b b=%0b exp a=0 b=0", a_ready, b_ready);
    end
    checks++; if (wr_en !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0) begin
      errors++; $display("FAIL rif_wb got wr=%0b addr=%0d data=%h exp 0/0/0", wr_en, rd_addr, rd_data);
    end
    checks++; if (hazard !== 1'b0 || proto_err !== 1'b0) begin
      errors++; $display("FAIL rif_flags got haz=%0b perr=%0b exp 0/0", hazard, proto_err);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      errors++; $display("FAIL rif_normal got a=%0b b=%0b exp a=1 b=0", a_ready, b_ready);
    end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL rif_hazard_post got=%0b exp=0", hazard); end
    idle_inputs();
    tick();
  endtask

  task automatic test_force_drop;
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h0000_0001;
    b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h0000_0005;
    repeat (4) tick();
    b_valid = 1'b0;
    #1;
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0 || wr_en !== 1'b0 || rd_addr !== 5'd0) begin
      errors++; $display("FAIL drop_no_grant got a=%0b b=%0b wr=%0b addr=%0d exp 0/0/0/0", a_ready, b_ready, wr_en, rd_addr);
    end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL drop_early got=%0b exp=0", proto_err); end
    tick();
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL drop_back_normal got=%0b exp=1", a_ready); end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL drop_proto got=%0b exp=1", proto_err); end
    idle_inputs();
    tick();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clear got=%0b exp=0", proto_err); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_a_only();
    test_hazard();
    test_starve();
    test_same_cycle();
    test_proto();
    test_reset_in_force();
    test_force_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/msrv32_wb_scheduler.md
MSRV32_WB_SCHEDULER -- requirements
Module: msrv32_wb_scheduler

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive denied cycles for requester B before B is force-granted (legal range 2..15).
REQ-002 SHALL have ports, in this order:
- ms_riscv32_mp_clk_in  in  1  clock.
- ms_riscv32_mp_rst_in  in  1  reset; asynchronous, active-high.
- a_valid_in  in  1  stage-3 writeback request.
- a_rd_addr_in  in  5  stage-3 destination register.
- a_rd_data_in  in  32  stage-3 write data.
- a_ready_out  out  1  stage-3 request accepted this cycle.
- b_valid_in  in  1  long-latency (load) writeback request.
- b_rd_addr_in  in  5  load destination register.
- b_rd_data_in  in  32  load write data.
- b_ready_out  out  1  load request accepted this cycle.
- issue_valid_in  in  1  a long-latency op is issued this cycle.
- issue_rd_addr_in  in  5  destination of the issued op.
- rs_1_addr_in, rs_2_addr_in  in  5 each  source registers of the decoding instruction.
- hazard_out  out  1  a source register has a write pending; stall decode.
- rd_addr_out  out  5  to register file.
- wr_en_out  out  1  to register file.
- rd_out  out  32  to register file.
- proto_err_out  out  1  sticky protocol-error flag.

Function
REQ-003 SHALL implement a 2-state FSM: NORMAL, FORCE_B.
REQ-004 In NORMAL: a_valid_in=1 -> grant A; else b_valid_in=1 -> grant B; else no grant.
REQ-005 The starvation counter SHALL increment in each NORMAL cycle with b_valid_in=1 and B not granted, and clear on any B grant or when b_valid_in=0.
REQ-006 When the counter would reach STARVE_LIMIT, the FSM SHALL enter FORCE_B on the next edge and clear the counter.
REQ-007 In FORCE_B: a_ready_out=0; grant B if b_valid_in=1; FSM returns to NORMAL on the next edge regardless.
REQ-008 In FORCE_B with b_valid_in=0 (B dropped its request), there SHALL be no grant, and proto_err_out SHALL set.
REQ-009 Grant outputs SHALL be combinational in the same cycle (zero latency): the granted requester's ready=1; rd_addr_out/rd_out = granted addr/data; wr_en_out=1 iff grant and addr!=0.
REQ-010 With no grant: wr_en_out=0, rd_addr_out=0, rd_out=0.
REQ-011 A requester with valid=1 and ready=0 SHALL hold addr/data stable; only the granted requester's handshake completes.
REQ-012 The scoreboard SHALL keep a 32-bit pending vector; issue_valid_in with issue_rd_addr_in!=0 sets the bit on the next edge.
REQ-013 A completed B handshake SHALL clear the bit for b_rd_addr_in on the next edge; a simultaneous set and clear of the same bit SHALL leave it set.
REQ-014 A B completion to a non-pending register (addr!=0) SHALL set proto_err_out.
REQ-015 hazard_out SHALL be 1 iff rs_1 or rs_2 (nonzero) is pending, excluding a register being cleared by a B write granted in the same cycle (the register file forwards it).
REQ-016 A writes SHALL NOT touch the scoreboard.

Reset
REQ-017 Asynchronous assertion SHALL force: FSM=NORMAL, counter=0, pending vector=0, proto_err_out=0.
REQ-018 During reset all grant outputs, hazard_out and proto_err_out SHALL be 0; a reset mid-FORCE_B discards the forced grant.
REQ-019 proto_err_out SHALL clear only on reset.

Structure
REQ-020 Package msrv32_pkg SHALL hold the FSM state enum and the STARVE_LIMIT default constant.
REQ-021 The pending vector plus hazard logic SHALL be a sub-module, msrv32_scoreboard; the arbiter FSM stays in the top module.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- A only, a_rd_addr=5, data=0xDEADBEEF -> same-cycle wr_en_out=1, rd_addr_out=5, a_ready_out=1.
- Issue rd=7 at cycle 0, rs_1=7 -> hazard_out=1 from cycle 1 until B writes 7; in the B-write cycle hazard_out=0; the bit clears the next cycle.
- A and B valid continuously, STARVE_LIMIT=4 -> B denied 4 cycles; cycle 5 a_ready_out=0, b_ready_out=1; cycle 6 A granted.
- Issue rd=3 and B completion rd=3 in the same cycle -> bit 3 remains pending.
- B completion to rd=9 with nothing pending -> proto_err_out=1, held until reset; writes to x0 give wr_en_out=0.
- Reset asserted in FORCE_B -> all outputs 0 immediately; after release, FSM=NORMAL and hazard_out=0.
